// File: rtl/uart_echo_fifo.sv
`timescale 1ns/1ps
// uart_echo_fifo: UART receiver -> FIFO -> UART transmitter echo path.
// Received good frames are reported on rx_valid/rx_byte and queued. The
// transmitter drains the queue back onto tx unless tx_hold is asserted.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit after the
// data bits in both directions and enables parity_err.
module uart_echo_fifo #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx,
    output logic                             tx,
    input  logic                             tx_hold,
    output logic                             rx_valid,
    output logic [DATA_BITS-1:0]             rx_byte,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow,
    output logic                             frame_err,
    output logic                             parity_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = $clog2(DATA_BITS);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W        = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
`ifdef UART_PARITY_EN
        R_PARITY,
`endif
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
`ifdef UART_PARITY_EN
        T_PARITY,
`endif
        T_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall_c;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall_c = rx_prev & ~rx_sync;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t            rx_state;
    rx_state_t            rx_state_next;
    logic [CNT_W-1:0]     rx_cnt;
    logic [CNT_W-1:0]     rx_cnt_next;
    logic [BIT_W-1:0]     rx_bit;
    logic [BIT_W-1:0]     rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift;
    logic [DATA_BITS-1:0] rx_shift_next;
    logic                 frame_ok_c;
    logic                 stop_bad_c;
`ifdef UART_PARITY_EN
    logic                 rx_par;
    logic                 rx_par_next;
    logic                 par_bad_c;
`endif

    // RX state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
`ifdef UART_PARITY_EN
            rx_par   <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_bit   <= rx_bit_next;
            rx_shift <= rx_shift_next;
`ifdef UART_PARITY_EN
            rx_par   <= rx_par_next;
`endif
        end
    end

    // RX next state: half-bit start check, then mid-bit samples per bit.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt + CNT_W'(1);
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        frame_ok_c    = 1'b0;
        stop_bad_c    = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_next   = rx_par;
        par_bad_c     = 1'b0;
`endif
        case (rx_state)
            R_IDLE: begin
                rx_cnt_next = '0;
                if (rx_fall_c) begin
                    rx_state_next = R_START;
                end
            end
            R_START: begin
                if (rx_cnt == CNT_W'(HALF_BIT - 1)) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        rx_state_next = R_PARITY;
`else
                        rx_state_next = R_STOP;
`endif
                    end else begin
                        rx_bit_next = rx_bit + BIT_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            R_PARITY: begin
                if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_next   = '0;
                    rx_par_next   = rx_sync;
                    rx_state_next = R_STOP;
                end
            end
`endif
            R_STOP: begin
                if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_next   = '0;
                    rx_state_next = R_IDLE;
                    stop_bad_c    = ~rx_sync;
`ifdef UART_PARITY_EN
                    par_bad_c     = rx_par ^ (^rx_shift);
                    frame_ok_c    = rx_sync & ~par_bad_c;
`else
                    frame_ok_c    = rx_sync;
`endif
                end
            end
            default: begin
                rx_state_next = R_IDLE;
            end
        endcase
    end

    // RX outputs and sticky error flags, one cycle after the stop sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_valid <= frame_ok_c;
            if (frame_ok_c) begin
                rx_byte <= rx_shift;
            end
            if (stop_bad_c) begin
                frame_err <= 1'b1;
            end
        end
    end

`ifdef UART_PARITY_EN
    // Sticky parity error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (par_bad_c) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 full_c;
    logic                 push_ok_c;
    logic                 pop_c;

    // Full is judged on the occupancy before this cycle, so a same-cycle pop never rescues a push.
    assign full_c    = (fifo_count == OCC_W'(FIFO_DEPTH));
    assign push_ok_c = rx_valid & ~full_c;

    // Storage array; written only by accepted pushes.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok_c, pop_c})
                2'b10:   fifo_count <= fifo_count + OCC_W'(1);
                2'b01:   fifo_count <= fifo_count - OCC_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (rx_valid && full_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t            tx_state;
    tx_state_t            tx_state_next;
    logic [CNT_W-1:0]     tx_cnt;
    logic [CNT_W-1:0]     tx_cnt_next;
    logic [BIT_W-1:0]     tx_bit;
    logic [BIT_W-1:0]     tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DATA_BITS-1:0] tx_shift_next;
    logic                 tx_next;
`ifdef UART_PARITY_EN
    logic                 tx_par;
    logic                 tx_par_next;
`endif

    // TX state, datapath and registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            tx       <= tx_next;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_next;
`endif
        end
    end

    // TX next state: pop from idle, then one CLKS_PER_BIT slot per bit.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt + CNT_W'(1);
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        pop_c         = 1'b0;
        tx_next       = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_next   = tx_par;
`endif
        case (tx_state)
            T_IDLE: begin
                tx_cnt_next = '0;
                if ((fifo_count != '0) && !tx_hold) begin
                    pop_c         = 1'b1;
                    tx_shift_next = mem[rd_ptr];
                    tx_bit_next   = '0;
                    tx_state_next = T_START;
`ifdef UART_PARITY_EN
                    tx_par_next   = ^mem[rd_ptr];
`endif
                end
            end
            T_START: begin
                if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    tx_cnt_next   = '0;
                    tx_state_next = T_DATA;
                end
            end
            T_DATA: begin
                if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    tx_cnt_next = '0;
                    if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        tx_state_next = T_PARITY;
`else
                        tx_state_next = T_STOP;
`endif
                    end else begin
                        tx_bit_next   = tx_bit + BIT_W'(1);
                        tx_shift_next = tx_shift >> 1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            T_PARITY: begin
                if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    tx_cnt_next   = '0;
                    tx_state_next = T_STOP;
                end
            end
`endif
            T_STOP: begin
                if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    tx_cnt_next   = '0;
                    tx_state_next = T_IDLE;
                end
            end
            default: begin
                tx_state_next = T_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx stays registered.
        case (tx_state_next)
            T_START:  tx_next = 1'b0;
            T_DATA:   tx_next = tx_shift_next[0];
`ifdef UART_PARITY_EN
            T_PARITY: tx_next = tx_par_next;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
`timescale 1ns/1ps
// Bench for uart_echo_fifo: directed frames, queue-based scoreboard with
// independent RX-output and TX-line monitors.
module tb_uart_echo_fifo;

    localparam int unsigned CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       tx;
    logic       tx_hold;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    bit lat_check = 1'b0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    uart_echo_fifo #(
        .CLK_HZ    (1_000_000),
        .BAUD      (100_000),
        .DATA_BITS (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .tx        (tx),
        .tx_hold   (tx_hold),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_start_data(input logic [7:0] data);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(posedge clk);
        end
    endtask

    task automatic send_stop(input logic stop);
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (3) @(posedge clk);
    endtask

`ifdef UART_PARITY_EN
    task automatic send_frame_par(input logic [7:0] data, input logic par, input logic stop);
        send_start_data(data);
        rx = par;
        repeat (CPB) @(posedge clk);
        send_stop(stop);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_frame_par(data, ^data, stop);
    endtask
`else
    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_start_data(data);
        send_stop(stop);
    endtask
`endif

    // Wait for every expected TX frame to start, then for the last one to finish.
    task automatic wait_tx_drain(input int budget);
        for (int i = 0; i < budget && exp_tx.size() != 0; i++) @(posedge clk);
        repeat (12 * CPB) @(posedge clk);
        check("tx_drain_pending", 32'(exp_tx.size()), 0);
    endtask

    // RX monitor: every rx_valid pulse must match the next expected byte.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (!rst && rx_valid) begin
                last_valid_cyc = cyc;
                check("rx_valid_expected", 32'(exp_rx.size() != 0), 1);
                if (exp_rx.size() != 0) begin
                    exp_b = exp_rx.pop_front();
                    check("rx_byte", 32'(rx_byte), 32'(exp_b));
                end
            end
        end
    end

    // TX monitor: decode each frame on the line at mid-bit and compare.
    initial begin
        logic [7:0] got;
        logic [7:0] exp_b;
        logic       tx_prev;
        bit         have;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && tx_prev && !tx) begin
                if (lat_check) begin
                    check("tx_fall_latency", 32'(cyc - last_valid_cyc), 2);
                    lat_check = 1'b0;
                end
                have = (exp_tx.size() != 0);
                check("tx_frame_expected", 32'(have), 1);
                exp_b = 8'h00;
                if (have) exp_b = exp_tx.pop_front();
                repeat (CPB / 2) @(negedge clk);
                check("tx_start_bit", 32'(tx), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = tx;
                end
                check("tx_data", 32'(got), 32'(exp_b));
`ifdef UART_PARITY_EN
                repeat (CPB) @(negedge clk);
                check("tx_parity_bit", 32'(tx), 32'(^exp_b));
`endif
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", 32'(tx), 1);
            end
            tx_prev = tx;
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        tx_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 32'(tx), 1);
        check("reset_fifo_count", 32'(fifo_count), 0);
        check("reset_rx_valid", 32'(rx_valid), 0);
        check("reset_rx_byte", 32'(rx_byte), 0);
        check("reset_overflow", 32'(overflow), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_parity_err", 32'(parity_err), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Single byte echo with latency check.
        lat_check = 1'b1;
        exp_rx.push_back(8'hA5);
        exp_tx.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_tx_drain(400);
        check("echo_latency_seen", 32'(lat_check), 0);

        // Short low glitch is rejected.
        @(posedge clk);
        rx = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("glitch_fifo_count", 32'(fifo_count), 0);
        check("glitch_frame_err", 32'(frame_err), 0);
        check("glitch_tx_idle", 32'(tx), 1);

        // Bad stop bit.
        send_frame(8'h3C, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("badstop_frame_err", 32'(frame_err), 1);
        check("badstop_fifo_count", 32'(fifo_count), 0);
        check("badstop_tx_idle", 32'(tx), 1);
        check("badstop_overflow", 32'(overflow), 0);

        // Fill past capacity while held, then drain in order.
        tx_hold = 1'b1;
        for (int b = 1; b <= 6; b++) begin
            exp_rx.push_back(8'(b));
            if (b <= 4) exp_tx.push_back(8'(b));
            send_frame(8'(b), 1'b1);
            if (b == 4) begin
                @(negedge clk);
                check("fill4_fifo_count", 32'(fifo_count), 4);
                check("fill4_overflow", 32'(overflow), 0);
            end
        end
        @(negedge clk);
        check("held_fifo_count", 32'(fifo_count), 4);
        check("held_overflow", 32'(overflow), 1);
        check("held_tx_idle", 32'(tx), 1);
        tx_hold = 1'b0;
        wait_tx_drain(2000);
        @(negedge clk);
        check("drained_fifo_count", 32'(fifo_count), 0);

`ifdef UART_PARITY_EN
        // Wrong parity is dropped, right parity is echoed.
        send_frame_par(8'h07, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("badpar_parity_err", 32'(parity_err), 1);
        check("badpar_fifo_count", 32'(fifo_count), 0);
        exp_rx.push_back(8'h07);
        exp_tx.push_back(8'h07);
        send_frame_par(8'h07, 1'b1, 1'b1);
        wait_tx_drain(400);
`else
        @(negedge clk);
        check("parity_err_tied", 32'(parity_err), 0);
`endif

        check("rx_expected_left", 32'(exp_rx.size()), 0);
        check("tx_expected_left", 32'(exp_tx.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
